// File: rtl/ssd_counter_ctrl.sv
// Hex counter control for a seven-segment digit: debounced run/clear buttons, IDLE/RUN/PAUSE FSM, up/down count.
// A press acts DEBOUNCE+4 cycles after the raw edge; no backpressure, all outputs are free-running flops.
module ssd_counter_ctrl #(
  parameter int PRESCALE = 1000,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_run_i,
  input  logic       btn_clr_i,
  input  logic       dir_i,
  input  logic       load_en_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] digit_o,
  output logic       idle_o,
  output logic       running_o,
  output logic       wrap_o
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Bit 0 is the run button, bit 1 the clear button.
  logic [1:0]          btn_raw;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          db_lvl;
  logic [1:0]          db_prev;
  logic [1:0]          press;
  logic [1:0][DBW-1:0] db_cnt;

  logic                run_press;
  logic                clr_press;

  state_t              state_q;
  state_t              state_d;
  logic [PSW-1:0]      presc_q;
  logic [PSW-1:0]      presc_d;
  logic [3:0]          digit_d;
  logic                wrap_d;
  logic                step;

  assign btn_raw   = {btn_clr_i, btn_run_i};
  assign run_press = press[0];
  assign clr_press = press[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // The level flips only after DEBOUNCE consecutive disagreeing cycles; one agreeing cycle restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_lvl  <= '0;
      db_prev <= '0;
      press   <= '0;
      db_cnt  <= '0;
    end else begin
      db_prev <= db_lvl;
      press   <= db_lvl & ~db_prev;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    digit_d = digit_o;
    wrap_d  = 1'b0;
    step    = 1'b0;

    // Counting uses the current state, so the cycle a pause press lands still counts.
    if (state_q == ST_RUN) begin
      if (presc_q == PS_LAST) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + PSW'(1);
      end
    end

    if (step) begin
      if (dir_i) begin
        digit_d = digit_o + 4'd1;
        wrap_d  = (digit_o == 4'hf);
      end else begin
        digit_d = digit_o - 4'd1;
        wrap_d  = (digit_o == 4'h0);
      end
    end else if (load_en_i && (state_q != ST_RUN)) begin
      digit_d = load_val_i;
    end

    if (run_press) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          presc_d = '0;
        end
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end

    if (clr_press) begin
      state_d = ST_IDLE;
      presc_d = '0;
      digit_d = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      digit_o   <= '0;
      wrap_o    <= 1'b0;
      idle_o    <= 1'b1;
      running_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      digit_o   <= digit_d;
      wrap_o    <= wrap_d;
      idle_o    <= (state_d == ST_IDLE);
      running_o <= (state_d == ST_RUN);
    end
  end

endmodule
